response_frame_tx: RTL
======================

RESPONSE_FRAME_TX -- requirements
Module: response_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port send  input  1  request to transmit one response frame.
REQ-005 SHALL have port word_sel  input  2  response type: 00 none, 01 MAX, 10 TRUE, 11 FALSE.
REQ-006 SHALL have port max_value  input  16  payload for MAX responses.
REQ-007 SHALL have port RsTx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port Tx_Ready  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL accept a request on a rising edge only when send=1, busy=0 and word_sel!=00.
REQ-011 SHALL ignore send while busy=1, and SHALL ignore send with word_sel=00 (no frame, busy stays 0).
REQ-012 SHALL latch word_sel and max_value at acceptance; later input changes SHALL NOT affect the frame.
REQ-013 SHALL send the frame byte order: header 0xA5, then type byte (MAX 0x4D, TRUE 0x54, FALSE 0x46), then payload.
REQ-014 SHALL send the payload as max_value[15:8] then max_value[7:0] for MAX, 0x01 for TRUE, and 0x00 for FALSE.
REQ-015 SHALL send each byte as a start bit (0), data bits 0..7, and a stop bit (1), with each bit held for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL send the next byte's start bit immediately after the previous stop bit, with no idle gap.
REQ-017 SHALL drive busy=1 and RsTx=0 (start bit) in the first cycle after the accepting edge.
REQ-018 SHALL use the state machine IDLE -> START -> DATA(x8) -> STOP -> (START if bytes remain, else DONE) -> IDLE.
REQ-019 SHALL, in DONE, last one cycle with Tx_Ready=1, busy=0 and RsTx=1.
REQ-020 SHALL accept a send arriving during the DONE cycle, so that back-to-back frames are separated by exactly one idle-high cycle.
REQ-021 SHALL hold RsTx=1 in IDLE and DONE.
REQ-022 SHALL use a bit-timing counter that counts 0..CLKS_PER_BIT-1 and wraps, together with a 3-bit data index and a byte index.
REQ-023 SHALL NOT emit glitches on RsTx, which SHALL be driven from a register.

Reset
REQ-024 SHALL, on reset assertion, immediately force RsTx=1, busy=0, Tx_Ready=0 and state IDLE, and clear all counters and latched data.
REQ-025 SHALL abort a frame in progress when reset is asserted mid-frame, with no Tx_Ready pulse; the first send after reset release SHALL start a fresh frame from the header.

Configuration
REQ-026 SHALL support the macro RESP_CHECKSUM_EN: when defined, one extra byte (the XOR of all preceding frame bytes) SHALL be appended after the payload.
REQ-027 SHALL, with RESP_CHECKSUM_EN undefined, end the frame after the payload, with Tx_Ready timing reduced by one byte time.

Verification
REQ-028 SHALL cover, with CLKS_PER_BIT=4 and the checksum enabled: send, word_sel=10 -> bytes A5 54 01 F0; busy high for 160 cycles, then a Tx_Ready pulse.
REQ-029 SHALL cover, with CLKS_PER_BIT=4 and the checksum enabled: send, word_sel=01, max_value=0x1234 -> bytes A5 4D 12 34 CE over 200 cycles; max_value changed mid-frame has no effect.
REQ-030 SHALL cover, with CLKS_PER_BIT=4 and the checksum disabled: word_sel=11 -> bytes A5 46 00; Tx_Ready at cycle 120.
REQ-031 SHALL cover: send pulsed during busy and send with word_sel=00 in IDLE -> ignored; exactly one frame is sent and busy stays low for the 00 case.
REQ-032 SHALL cover: reset asserted at cycle 50 of a TRUE frame -> RsTx=1 and busy=0 immediately, with no Tx_Ready; the next send yields a complete A5 54 01 F0 frame.
REQ-033 SHALL cover: send held high with word_sel=10 -> consecutive frames separated by exactly one RsTx-high DONE cycle.

Source files
------------

// File: rtl/response_frame_tx.sv
// UART response-frame transmitter: header, type, payload and optional XOR checksum, 8N1.
// Optional checksum byte is enabled by defining RESP_CHECKSUM_EN.
module response_frame_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [1:0]  word_sel,
  input  logic [15:0] max_value,
  output logic        RsTx,
  output logic        busy,
  output logic        Tx_Ready
);

  // state | meaning
  // IDLE  | line high, waiting for an accepted send
  // START | start bit (0) of the current byte
  // DATA  | data bits 0..7, LSB first
  // STOP  | stop bit (1); then next byte or DONE
  // DONE  | one-cycle Tx_Ready pulse; a new send is accepted here
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  localparam logic [1:0]  SEL_NONE = 2'b00;
  localparam logic [1:0]  SEL_MAX  = 2'b01;
  localparam logic [1:0]  SEL_TRUE = 2'b10;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [2:0]  byte_idx, byte_idx_d;
  logic [1:0]  sel, sel_d;
  logic [15:0] val, val_d;
  logic [7:0]  shreg, shreg_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;

  logic        is_max;
  logic [7:0]  type_byte, pay_hi, pay_lo, chk, next_byte;
  logic [2:0]  last_idx, byte_nxt;
  logic        bit_wrap;

  assign is_max    = (sel == SEL_MAX);
  assign type_byte = is_max ? 8'h4D : ((sel == SEL_TRUE) ? 8'h54 : 8'h46);
  assign pay_hi    = is_max ? val[15:8] : ((sel == SEL_TRUE) ? 8'h01 : 8'h00);
  assign pay_lo    = is_max ? val[7:0] : 8'h00;
  assign chk       = 8'hA5 ^ type_byte ^ pay_hi ^ pay_lo;
  assign byte_nxt  = byte_idx + 3'd1;
  assign bit_wrap  = (cnt == BIT_LAST);

`ifdef RESP_CHECKSUM_EN
  assign last_idx = is_max ? 3'd4 : 3'd3;
`else
  assign last_idx = is_max ? 3'd3 : 3'd2;
`endif

  // Byte 3 is the low payload byte for MAX, otherwise the checksum slot.
  always_comb begin
    case (byte_nxt)
      3'd1:    next_byte = type_byte;
      3'd2:    next_byte = pay_hi;
      3'd3:    next_byte = is_max ? pay_lo : chk;
      default: next_byte = chk;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sel      <= '0;
      val      <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      sel      <= sel_d;
      val      <= val_d;
      shreg    <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

  // Outputs are computed for the next state so RsTx/busy/Tx_Ready come straight from flops.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    sel_d      = sel;
    val_d      = val;
    shreg_d    = shreg;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    rdy_d      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (send && (word_sel != SEL_NONE)) begin
          state_d    = START;
          sel_d      = word_sel;
          val_d      = max_value;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
          shreg_d    = 8'hA5;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        busy_d = 1'b1;
        if (bit_wrap) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shreg[0];
        end else begin
          cnt_d = cnt + 16'd1;
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        busy_d = 1'b1;
        if (bit_wrap) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
            tx_d      = shreg[1];
          end
        end else begin
          cnt_d = cnt + 16'd1;
          tx_d  = shreg[0];
        end
      end
      STOP: begin
        busy_d = 1'b1;
        if (bit_wrap) begin
          cnt_d = '0;
          if (byte_idx == last_idx) begin
            state_d = DONE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            byte_idx_d = byte_nxt;
            shreg_d    = next_byte;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RsTx     = tx_q;
  assign busy     = busy_q;
  assign Tx_Ready = rdy_q;

endmodule
